regfile_sb: RTL and testbench

Thirty-two-entry, 32-bit general-purpose register file with a load-use scoreboard. It sits directly downstream of the writeback select mux, whose 32-bit output drives `WD`. It supplies the two decode-stage operands and raises `STALL` while a source register still awaits an outstanding load. Register 0 is hard-wired to zero.

---
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// 32 x 32-bit register file with a load-use scoreboard that raises STALL on pending sources.
// Optional macro REGFILE_BYPASS_EN forwards WD to same-cycle reads instead of stalling them.
module regfile_sb #(
    parameter int ZERO_REG = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [0:4]  WA,
    input  logic [0:31] WD,
    input  logic [0:4]  RA1,
    input  logic [0:4]  RA2,
    input  logic        RE1,
    input  logic        RE2,
    output logic [0:31] RD1,
    output logic [0:31] RD2,
    input  logic        PEND_SET,
    input  logic [0:4]  PEND_A,
    output logic        STALL,
    output logic [15:0] STALL_CNT
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [0:31] regs_q [0:31];
    logic [0:31] pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_ok;
    logic        set_ok;

    logic [0:4]  ra [0:1];
    logic [0:1]  re;
    logic [0:31] rd [0:1];
    logic [0:1]  rd_zero;
    logic [0:1]  rd_hit;
    logic [0:1]  haz;

    assign ra[0] = RA1;
    assign ra[1] = RA2;
    assign re    = {RE1, RE2};

    assign wr_ok  = WE & ~(ZR & (WA == 5'd0));
    assign set_ok = PEND_SET & ~(ZR & (PEND_A == 5'd0));

    always_comb begin
        rd_zero = '0;
        rd_hit  = '0;
        haz     = '0;
        rd[0]   = '0;
        rd[1]   = '0;
        for (int p = 0; p < 2; p++) begin
            rd_zero[p] = ZR & (ra[p] == 5'd0);
            rd_hit[p]  = WE & (WA == ra[p]) & ~rd_zero[p];
            rd[p]      = rd_zero[p] ? '0 : regs_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (rd_hit[p]) begin
                rd[p] = WD;
            end
            haz[p] = re[p] & pend_q[ra[p]] & ~(WE & (WA == ra[p]));
`else
            // Same-cycle write to a source: stall so decode re-reads the committed value.
            haz[p] = re[p] & (pend_q[ra[p]] | rd_hit[p]);
`endif
        end
    end

    assign RD1   = RST ? '0 : rd[0];
    assign RD2   = RST ? '0 : rd[1];
    assign STALL = ~RST & (|haz);

    // A new load outranks a retiring writeback to the same register.
    always_comb begin
        pend_d = pend_q;
        if (WE) begin
            pend_d[WA] = 1'b0;
        end
        if (set_ok) begin
            pend_d[PEND_A] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (STALL && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[WA] <= WD;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan steps plus random traffic against a behavioural model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        WE;
    logic [0:4]  WA;
    logic [0:31] WD;
    logic [0:4]  RA1, RA2;
    logic        RE1, RE2;
    logic [0:31] RD1, RD2;
    logic        PEND_SET;
    logic [0:4]  PEND_A;
    logic        STALL;
    logic [15:0] STALL_CNT;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [15:0] m_cnt;
    logic [15:0] base;

    regfile_sb #(.ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RE1(RE1), .RE2(RE2),
        .RD1(RD1), .RD2(RD2), .PEND_SET(PEND_SET), .PEND_A(PEND_A),
        .STALL(STALL), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (RST) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (BYP && WE && (WA == ra)) return WD;
        return m_regs[ra];
    endfunction

    function automatic bit port_stall(input bit re, input logic [4:0] ra);
        bit writing;
        writing = WE && (WA == ra);
        if (!re) return 1'b0;
        if (BYP) return m_pend[ra] && !writing;
        return m_pend[ra] || (writing && (ra != 5'd0));
    endfunction

    function automatic bit exp_stall();
        if (RST) return 1'b0;
        return port_stall(RE1, RA1) || port_stall(RE2, RA2);
    endfunction

    task automatic settle();
        @(negedge CLK);
        chk("rd1", RD1, exp_rd(RA1));
        chk("rd2", RD2, exp_rd(RA2));
        chk("stall", {31'b0, STALL}, {31'b0, exp_stall()});
        chk("stall_cnt", {16'b0, STALL_CNT}, {16'b0, m_cnt});
    endtask

    task automatic advance();
        bit s;
        s = exp_stall();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_cnt = 16'h0;
        end else begin
            if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (WE && WA != 5'd0) m_regs[WA] = WD;
            if (WE) m_pend[WA] = 1'b0;
            if (PEND_SET && PEND_A != 5'd0) m_pend[PEND_A] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        WE = 0; WA = 0; WD = 0; RA1 = 0; RA2 = 0; RE1 = 0; RE2 = 0;
        PEND_SET = 0; PEND_A = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_cnt = 16'h0;
        RST = 1;
        idle_inputs();
        advance();
        advance();
        RST = 0;

        // Reset state across all addresses
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i); RE1 = 1; RE2 = 1;
            settle();
            chk("reset_rd1", RD1, 32'h0);
            chk("reset_rd2", RD2, 32'h0);
            chk("reset_stall", {31'b0, STALL}, 32'h0);
            chk("reset_cnt", {16'b0, STALL_CNT}, 32'h0);
            advance();
        end

        // Same-cycle write and read of r5
        idle_inputs();
        WE = 1; WA = 5; WD = 32'hDEADBEEF; RA1 = 5; RE1 = 1;
        settle();
        chk("wr5_same_rd1", RD1, BYP ? 32'hDEADBEEF : 32'h0);
        chk("wr5_same_stall", {31'b0, STALL}, BYP ? 32'h0 : 32'h1);
        advance();
        WE = 0;
        settle();
        chk("wr5_next_rd1", RD1, 32'hDEADBEEF);
        chk("wr5_next_stall", {31'b0, STALL}, 32'h0);
        advance();

        // r0 is hard-wired zero
        WE = 1; WA = 0; WD = 32'h12345678; RA1 = 0; RE1 = 1;
        settle();
        chk("r0_same_rd1", RD1, 32'h0);
        advance();
        WE = 0; PEND_SET = 1; PEND_A = 0;
        settle();
        chk("r0_rd1", RD1, 32'h0);
        advance();
        PEND_SET = 0;
        settle();
        chk("r0_pend_stall", {31'b0, STALL}, 32'h0);
        advance();

        // Load-use on r7 with writeback in cycle 4
        idle_inputs();
        base = m_cnt;
        PEND_SET = 1; PEND_A = 7; RE2 = 1; RA2 = 7;
        settle();
        chk("r7_c1_stall", {31'b0, STALL}, 32'h0);
        advance();
        PEND_SET = 0;
        settle();
        chk("r7_c2_stall", {31'b0, STALL}, 32'h1);
        advance();
        settle();
        chk("r7_c3_stall", {31'b0, STALL}, 32'h1);
        advance();
        WE = 1; WA = 7; WD = 32'hA5A5A5A5;
        settle();
        chk("r7_c4_stall", {31'b0, STALL}, BYP ? 32'h0 : 32'h1);
        chk("r7_c4_rd2", RD2, BYP ? 32'hA5A5A5A5 : 32'h0);
        advance();
        WE = 0;
        settle();
        chk("r7_c5_stall", {31'b0, STALL}, 32'h0);
        chk("r7_c5_rd2", RD2, 32'hA5A5A5A5);
        chk("r7_cnt", {16'b0, STALL_CNT}, {16'b0, base + (BYP ? 16'd2 : 16'd3)});
        advance();

        // Set wins over clear on r9
        idle_inputs();
        PEND_SET = 1; PEND_A = 9; WE = 1; WA = 9; WD = 32'h00000099;
        advance();
        idle_inputs();
        RE1 = 1; RA1 = 9;
        settle();
        chk("r9_set_wins_stall", {31'b0, STALL}, 32'h1);
        chk("r9_rd1", RD1, 32'h00000099);
        advance();
        WE = 1; WA = 9; WD = 32'h0000AAAA;
        advance();
        WE = 0;
        settle();
        chk("r9_cleared_stall", {31'b0, STALL}, 32'h0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            RST      = ($urandom_range(0, 49) == 0);
            WE       = 1'($urandom_range(0, 1));
            WA       = 5'($urandom_range(0, 7));
            WD       = $urandom;
            RA1      = 5'($urandom_range(0, 7));
            RA2      = 5'($urandom_range(0, 7));
            RE1      = 1'($urandom_range(0, 1));
            RE2      = 1'($urandom_range(0, 1));
            PEND_SET = ($urandom_range(0, 3) == 0);
            PEND_A   = 5'($urandom_range(0, 7));
            settle();
            advance();
        end

        // Counter saturation, then reset mid-stall
        RST = 1;
        idle_inputs();
        advance();
        RST = 0;
        PEND_SET = 1; PEND_A = 3;
        advance();
        PEND_SET = 0; RE1 = 1; RA1 = 3;
        for (int n = 0; n < 70000; n++) begin
            advance();
        end
        settle();
        chk("sat_cnt", {16'b0, STALL_CNT}, 32'h0000FFFF);
        chk("sat_stall", {31'b0, STALL}, 32'h1);
        advance();
        RST = 1;
        settle();
        chk("rst_stall_forced", {31'b0, STALL}, 32'h0);
        advance();
        RST = 0;
        settle();
        chk("post_rst_stall", {31'b0, STALL}, 32'h0);
        chk("post_rst_cnt", {16'b0, STALL_CNT}, 32'h0);
        advance();
        RE1 = 0; WE = 1; WA = 3; WD = 32'hCAFEF00D;
        advance();
        WE = 0; RE1 = 1;
        settle();
        chk("post_rst_wr_rd1", RD1, 32'hCAFEF00D);
        chk("post_rst_wr_stall", {31'b0, STALL}, 32'h0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
